// File: rtl/uart_rx_dma_if.sv
// uart_rx_dma_if
//   DMA write-channel bundle between the UART ingest block and the DMA engine.
//   master : the ingest block (drives address, request, data, size, ready)
//   slave  : the DMA engine (drives busy and per-word accept)
//   dma_waddr  - burst start byte address
//   dma_wareq  - one-cycle burst request pulse
//   dma_wbusy  - engine busy with a write burst
//   dma_wdata  - write word, valid while dma_wready is high
//   dma_wsize  - burst length in 64-bit words
//   dma_wvalid - engine accepts a word this cycle
//   dma_wready - block presents a word on dma_wdata
interface uart_rx_dma_if;
   logic [31:0] dma_waddr;
   logic        dma_wareq;
   logic        dma_wbusy;
   logic [63:0] dma_wdata;
   logic [15:0] dma_wsize;
   logic        dma_wvalid;
   logic        dma_wready;

   modport master (
      output dma_waddr, dma_wareq, dma_wdata, dma_wsize, dma_wready,
      input  dma_wbusy, dma_wvalid
   );

   modport slave (
      input  dma_waddr, dma_wareq, dma_wdata, dma_wsize, dma_wready,
      output dma_wbusy, dma_wvalid
   );
endinterface

// File: rtl/uart_rx_dma.sv
// uart_rx_dma
//   UART-to-DDR ingest path. Receives UART bytes, packs them little-endian
//   into 64-bit words, buffers them in a 2*BURST_WORDS deep word FIFO and
//   pushes fixed-size bursts through the DMA write channel into a circular
//   DDR buffer at BASE_ADDR..BASE_ADDR+BUF_BYTES-1.
//
//   Ports:
//     clk_50M      - system clock
//     dma_rst_n    - asynchronous active-low reset
//     i_uart_rx    - UART serial input, idles high
//     dma          - DMA write channel (uart_rx_dma_if.master)
//     rx_frame_err - sticky, a byte was dropped on a bad stop (or parity) bit
//     rx_overflow  - sticky, a word was dropped because the FIFO was full
//
//   Build option: define UART_RX_PARITY_EN for 8E1 frames (PARITY state
//   between DATA and STOP). Undefined, frames are 8N1.
module uart_rx_dma #(
   parameter int          CLK_FREQ    = 50_000_000,
   parameter int          BAUD        = 115200,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter logic [31:0] BUF_BYTES   = 32'h0010_0000,
   parameter int          BURST_WORDS = 16
) (
   input  logic          clk_50M,
   input  logic          dma_rst_n,
   input  logic          i_uart_rx,
   uart_rx_dma_if.master dma,
   output logic          rx_frame_err,
   output logic          rx_overflow
);

   localparam int          BIT_CNT     = CLK_FREQ / BAUD;
   localparam int          HALF_CNT    = BIT_CNT / 2;
   localparam int          CW          = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
   localparam int          DEPTH       = 2 * BURST_WORDS;
   localparam int          PW          = $clog2(DEPTH);
   localparam int          CNTW        = $clog2(DEPTH + 1);
   localparam int          PCW         = $clog2(BURST_WORDS + 1);
   localparam logic [31:0] BURST_BYTES = 32'(BURST_WORDS * 8);
   localparam logic [31:0] END_ADDR    = BASE_ADDR + BUF_BYTES;

   // ------------------------------------------------------------------
   // RX synchronizer and falling-edge detect
   // ------------------------------------------------------------------
   logic rx_meta_q, rx_sync_q, rx_prev_q;
   logic rx_fall;

   always_ff @(posedge clk_50M or negedge dma_rst_n) begin
      if (!dma_rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= i_uart_rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_fall = rx_prev_q & ~rx_sync_q;

   // ------------------------------------------------------------------
   // RX FSM
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
`ifdef UART_RX_PARITY_EN
      RX_PARITY,
`endif
      RX_STOP
   } rx_state_e;

   rx_state_e         rx_state_q, rx_state_d;
   logic [CW-1:0]     baud_cnt_q, baud_cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              byte_vld_q, byte_vld_d;
   logic              frame_err_q;
   logic              frame_bad;
   logic              bit_tick;
   logic              stop_ok;
`ifdef UART_RX_PARITY_EN
   logic              par_err_q, par_err_d;
`endif

   assign bit_tick = (baud_cnt_q == CW'(BIT_CNT - 1));

`ifdef UART_RX_PARITY_EN
   assign stop_ok = rx_sync_q & ~par_err_q;
`else
   assign stop_ok = rx_sync_q;
`endif

   always_comb begin
      rx_state_d = rx_state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_vld_d = 1'b0;
      frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d  = par_err_q;
`endif
      case (rx_state_q)
         RX_IDLE: begin
            if (rx_fall) begin
               rx_state_d = RX_START;
               baud_cnt_d = '0;
            end
         end
         RX_START: begin
            // mid-start-bit sample; a high level here was only a glitch
            if (baud_cnt_q == CW'(HALF_CNT - 1)) begin
               baud_cnt_d = '0;
               bit_idx_d  = '0;
               rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (bit_tick) begin
               baud_cnt_d = '0;
               shift_d    = {rx_sync_q, shift_q[7:1]};   // LSB first
               bit_idx_d  = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  rx_state_d = RX_PARITY;
`else
                  rx_state_d = RX_STOP;
`endif
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (bit_tick) begin
               baud_cnt_d = '0;
               par_err_d  = ^{shift_q, rx_sync_q};     // even parity
               rx_state_d = RX_STOP;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
`endif
         RX_STOP: begin
            if (bit_tick) begin
               baud_cnt_d = '0;
               rx_state_d = RX_IDLE;
               if (stop_ok) byte_vld_d = 1'b1;
               else         frame_bad  = 1'b1;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge dma_rst_n) begin
      if (!dma_rst_n) begin
         rx_state_q  <= RX_IDLE;
         baud_cnt_q  <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         byte_vld_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= 1'b0;
`endif
      end else begin
         rx_state_q  <= rx_state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         byte_vld_q  <= byte_vld_d;
         frame_err_q <= frame_err_q | frame_bad;
`ifdef UART_RX_PARITY_EN
         par_err_q   <= par_err_d;
`endif
      end
   end

   // ------------------------------------------------------------------
   // Byte packer: byte k lands in bits [8k+7:8k]; the 8th byte is not
   // stored, it goes straight into the FIFO with the 7 held bytes.
   // ------------------------------------------------------------------
   logic [55:0] pack_q, pack_d;
   logic [2:0]  k_q, k_d;
   logic        push_req;
   logic [63:0] push_word;

   always_comb begin
      pack_d    = pack_q;
      k_d       = k_q;
      push_req  = 1'b0;
      push_word = {shift_q, pack_q};
      if (byte_vld_q) begin
         if (k_q == 3'd7) begin
            push_req = 1'b1;
            k_d      = 3'd0;
         end else begin
            pack_d[8*k_q +: 8] = shift_q;
            k_d                = k_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_50M or negedge dma_rst_n) begin
      if (!dma_rst_n) begin
         pack_q <= '0;
         k_q    <= '0;
      end else begin
         pack_q <= pack_d;
         k_q    <= k_d;
      end
   end

   // ------------------------------------------------------------------
   // Word FIFO with a registered head (head_q mirrors mem[rd_ptr]).
   // ------------------------------------------------------------------
   logic [63:0]     mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   rd_nxt;
   logic [CNTW-1:0] count_q, count_d;
   logic [63:0]     head_q, head_d;
   logic            overflow_q;
   logic            do_push, do_pop;
   logic            wready;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign do_push = push_req && (count_q != CNTW'(DEPTH));
   assign do_pop  = dma.dma_wvalid && wready;
   assign rd_nxt  = ptr_inc(rd_ptr_q);

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_nxt : rd_ptr_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // next head: the following stored word, or the word being pushed
      // when it is the only one left / the FIFO was empty
      head_d = head_q;
      if (do_pop) begin
         if (count_q > CNTW'(1))
            head_d = mem_q[rd_nxt];
         else if (do_push)
            head_d = push_word;
      end else if (count_q == '0 && do_push) begin
         head_d = push_word;
      end
   end

   always_ff @(posedge clk_50M) begin
      if (do_push) mem_q[wr_ptr_q] <= push_word;
   end

   always_ff @(posedge clk_50M or negedge dma_rst_n) begin
      if (!dma_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         head_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         head_q     <= head_d;
         overflow_q <= overflow_q | (push_req & ~do_push);
      end
   end

   // ------------------------------------------------------------------
   // DMA FSM
   // ------------------------------------------------------------------
   typedef enum logic [2:0] {
      D_IDLE,
      D_REQ,
      D_WAIT_BUSY,
      D_XFER,
      D_WAIT_DONE
   } dma_state_e;

   dma_state_e     dma_state_q, dma_state_d;
   logic [PCW-1:0] pop_cnt_q, pop_cnt_d;
   logic [31:0]    waddr_q, waddr_d;

   always_comb begin
      dma_state_d = dma_state_q;
      pop_cnt_d   = pop_cnt_q;
      waddr_d     = waddr_q;
      case (dma_state_q)
         D_IDLE: begin
            if (count_q >= CNTW'(BURST_WORDS) && !dma.dma_wbusy)
               dma_state_d = D_REQ;
         end
         D_REQ:       dma_state_d = D_WAIT_BUSY;
         D_WAIT_BUSY: if (dma.dma_wbusy) dma_state_d = D_XFER;
         D_XFER: begin
            if (do_pop) begin
               if (pop_cnt_q == PCW'(BURST_WORDS - 1)) begin
                  pop_cnt_d   = '0;
                  dma_state_d = D_WAIT_DONE;
               end else begin
                  pop_cnt_d = pop_cnt_q + 1'b1;
               end
            end
         end
         D_WAIT_DONE: begin
            if (!dma.dma_wbusy) begin
               dma_state_d = D_IDLE;
               waddr_d     = (waddr_q + BURST_BYTES == END_ADDR) ? BASE_ADDR
                                                                 : waddr_q + BURST_BYTES;
            end
         end
         default: dma_state_d = D_IDLE;
      endcase
   end

   always_ff @(posedge clk_50M or negedge dma_rst_n) begin
      if (!dma_rst_n) begin
         dma_state_q <= D_IDLE;
         pop_cnt_q   <= '0;
         waddr_q     <= BASE_ADDR;
      end else begin
         dma_state_q <= dma_state_d;
         pop_cnt_q   <= pop_cnt_d;
         waddr_q     <= waddr_d;
      end
   end

   assign wready         = (dma_state_q == D_XFER) && (count_q != '0);
   assign dma.dma_wready = wready;
   assign dma.dma_wareq  = (dma_state_q == D_REQ);
   assign dma.dma_waddr  = waddr_q;
   assign dma.dma_wdata  = head_q;
   assign dma.dma_wsize  = 16'(BURST_WORDS);
   assign rx_frame_err   = frame_err_q;
   assign rx_overflow    = overflow_q;

endmodule

// File: tb/tb_uart_rx_dma.sv
// tb_uart_rx_dma
//   Scoreboard bench for uart_rx_dma. The UART driver packs every good byte
//   into a reference word and queues it; a small DMA engine model accepts
//   words and compares them against the queue, and checks each burst address.
//   Runs at a fast baud (4 clocks per bit) with a 256-byte ring so the wrap
//   case is reached quickly.
module tb_uart_rx_dma;
   localparam int          CLK_HZ = 50_000_000;
   localparam int          BAUD   = 12_500_000;
   localparam int          BIT    = CLK_HZ / BAUD;
   localparam logic [31:0] BASE   = 32'h8000_1000;
   localparam logic [31:0] BUFB   = 32'd256;
   localparam int          BW     = 16;

   logic clk_50M   = 1'b0;
   logic dma_rst_n = 1'b0;
   logic i_uart_rx = 1'b1;
   logic rx_frame_err, rx_overflow;

   uart_rx_dma_if dif();

   uart_rx_dma #(
      .CLK_FREQ   (CLK_HZ),
      .BAUD       (BAUD),
      .BASE_ADDR  (BASE),
      .BUF_BYTES  (BUFB),
      .BURST_WORDS(BW)
   ) dut (
      .clk_50M     (clk_50M),
      .dma_rst_n   (dma_rst_n),
      .i_uart_rx   (i_uart_rx),
      .dma         (dif),
      .rx_frame_err(rx_frame_err),
      .rx_overflow (rx_overflow)
   );

   always #5 clk_50M = ~clk_50M;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // scoreboard and reference packer
   logic [63:0] exp_q[$];
   logic [63:0] tb_word;
   int          tb_k = 0;

   task automatic push_byte(input logic [7:0] b);
      tb_word[8*tb_k +: 8] = b;
      tb_k++;
      if (tb_k == 8) begin
         tb_k = 0;
         if (exp_q.size() < 2*BW) exp_q.push_back(tb_word);   // else: FIFO full, dropped
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic good);
      if (good) push_byte(b);
      i_uart_rx = 1'b0;
      repeat (BIT) @(negedge clk_50M);
      for (int i = 0; i < 8; i++) begin
         i_uart_rx = b[i];
         repeat (BIT) @(negedge clk_50M);
      end
`ifdef UART_RX_PARITY_EN
      i_uart_rx = ^b;
      repeat (BIT) @(negedge clk_50M);
`endif
      i_uart_rx = good;
      repeat (BIT) @(negedge clk_50M);
      i_uart_rx = 1'b1;
      repeat (BIT) @(negedge clk_50M);
   endtask

   // DMA engine model
   logic        eng_busy, tog, hold_busy, toggle_mode;
   int          eng_cnt, bursts;
   logic [31:0] exp_addr;
   logic [63:0] exp_w;

   initial begin
      eng_busy = 1'b0; eng_cnt = 0; bursts = 0; tog = 1'b0; exp_addr = BASE;
      hold_busy = 1'b0; toggle_mode = 1'b0;
      dif.dma_wbusy = 1'b0; dif.dma_wvalid = 1'b0;
      forever begin
         @(negedge clk_50M);
         if (!dma_rst_n) begin
            eng_busy = 1'b0; eng_cnt = 0; bursts = 0; exp_addr = BASE;
            dif.dma_wvalid = 1'b0;
         end else begin
            if (eng_busy && eng_cnt == BW) eng_busy = 1'b0;
            if (dif.dma_wareq) begin
               chk("burst_addr", 64'(dif.dma_waddr), 64'(exp_addr));
               chk("burst_size", 64'(dif.dma_wsize), 64'(BW));
               exp_addr = (exp_addr + 32'd128 == BASE + BUFB) ? BASE : exp_addr + 32'd128;
               bursts++;
               eng_busy = 1'b1;
               eng_cnt  = 0;
            end
            tog = ~tog;
            dif.dma_wvalid = eng_busy && (eng_cnt < BW) && (!toggle_mode || tog);
            if (dif.dma_wvalid && dif.dma_wready) begin
               if (exp_q.size() != 0) exp_w = exp_q.pop_front();
               else                   exp_w = 64'hDEAD_BEEF_DEAD_BEEF;
               chk("xfer_word", dif.dma_wdata, exp_w);
               eng_cnt++;
            end
         end
         dif.dma_wbusy = eng_busy | hold_busy;
      end
   end

   task automatic wait_idle(input int nb, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk_50M);
         if (bursts >= nb && !eng_busy && exp_q.size() == 0) break;
      end
      chk("burst_count", 64'(bursts), 64'(nb));
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_reset();
      dma_rst_n = 1'b0;
      repeat (3) @(negedge clk_50M);
      exp_q.delete();
      tb_k = 0;
      dma_rst_n = 1'b1;
      repeat (2) @(negedge clk_50M);
   endtask

   initial begin
      repeat (3) @(negedge clk_50M);
      chk("rst_waddr",  64'(dif.dma_waddr), 64'(BASE));
      chk("rst_wareq",  64'(dif.dma_wareq), 64'd0);
      chk("rst_wready", 64'(dif.dma_wready), 64'd0);
      chk("rst_wdata",  dif.dma_wdata, 64'd0);
      chk("rst_wsize",  64'(dif.dma_wsize), 64'(BW));
      chk("rst_ferr",   64'(rx_frame_err), 64'd0);
      chk("rst_ovf",    64'(rx_overflow), 64'd0);
      dma_rst_n = 1'b1;
      repeat (2) @(negedge clk_50M);

      // one burst of 0x00..0x7F, wvalid always high
      for (int i = 0; i < 128; i++) send_frame(8'(i), 1'b1);
      wait_idle(1, 2000);

      // three bursts, wvalid toggling; third burst wraps back to BASE
      do_reset();
      toggle_mode = 1'b1;
      for (int i = 0; i < 384; i++) send_frame(8'(i), 1'b1);
      wait_idle(3, 3000);
      toggle_mode = 1'b0;

      // bad stop bit and a short low glitch are both dropped
      do_reset();
      for (int i = 0; i < 4; i++) send_frame(8'(8'h40 + i), 1'b1);
      send_frame(8'hA5, 1'b0);
      chk("ferr_set", 64'(rx_frame_err), 64'd1);
      i_uart_rx = 1'b0;
      @(negedge clk_50M);
      i_uart_rx = 1'b1;
      repeat (2*BIT) @(negedge clk_50M);
      for (int i = 4; i < 128; i++) send_frame(8'(8'h40 + i), 1'b1);
      wait_idle(1, 2000);
      chk("ferr_sticky", 64'(rx_frame_err), 64'd1);
      chk("ferr_no_ovf", 64'(rx_overflow), 64'd0);

      // overflow with the engine held busy, then drain two bursts
      do_reset();
      chk("ferr_cleared", 64'(rx_frame_err), 64'd0);
      hold_busy = 1'b1;
      for (int i = 0; i < 264; i++) send_frame(8'(i*7 + 3), 1'b1);
      repeat (20) @(negedge clk_50M);
      chk("ovf_set", 64'(rx_overflow), 64'd1);
      chk("ovf_no_req", 64'(bursts), 64'd0);
      hold_busy = 1'b0;
      wait_idle(2, 3000);
      chk("ovf_sticky", 64'(rx_overflow), 64'd1);

      // reset in the middle of a transfer
      do_reset();
      for (int i = 0; i < 128; i++) send_frame(8'(8'hC0 ^ i), 1'b1);
      for (int i = 0; i < 2000 && eng_cnt < 5; i++) @(posedge clk_50M);
      @(posedge clk_50M);
      #1;
      chk("midrst_pre_wready", 64'(dif.dma_wready), 64'd1);
      #1 dma_rst_n = 1'b0;
      #1;
      chk("midrst_wready", 64'(dif.dma_wready), 64'd0);
      chk("midrst_waddr",  64'(dif.dma_waddr), 64'(BASE));
      chk("midrst_wdata",  dif.dma_wdata, 64'd0);
      chk("midrst_ovf",    64'(rx_overflow), 64'd0);
      repeat (3) @(negedge clk_50M);
      exp_q.delete();
      tb_k = 0;
      dma_rst_n = 1'b1;
      repeat (2) @(negedge clk_50M);
      for (int i = 0; i < 128; i++) send_frame(8'(255 - i), 1'b1);
      wait_idle(1, 2000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/uart_rx_dma.md
# uart_rx_dma

UART-to-DDR ingest path: receives 8N1 bytes on a UART pin, packs them little-endian into 64-bit words, buffers them in a word FIFO and pushes fixed-size bursts through the DMA write channel into a circular DDR buffer. It is the receive/write-side counterpart of the DMA-read-to-UART-transmit path. It sits beside the SD loader on the shared 50 MHz DMA clock domain.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD, 115200, UART bit rate
- BASE_ADDR, 32'h0000_0000, byte address of the DDR ring buffer
- BUF_BYTES, 32'h0010_0000, ring size in bytes; power of two and a multiple of BURST_WORDS*8
- BURST_WORDS, 16, 64-bit words per DMA write request; FIFO depth is 2*BURST_WORDS

Ports:
- clk_50M  in  1  system clock
- dma_rst_n  in  1  asynchronous active-low reset
- i_uart_rx  in  1  UART serial input; idles high
- dma_waddr  out  32  burst start byte address
- dma_wareq  out  1  one-cycle burst request pulse
- dma_wbusy  in  1  DMA engine busy with a write burst
- dma_wdata  out  64  write data, valid while dma_wready is high
- dma_wsize  out  16  burst length in words; constant BURST_WORDS
- dma_wvalid  in  1  DMA engine accepts a word this cycle
- dma_wready  out  1  block presents a word on dma_wdata
- rx_frame_err  out  1  sticky; a byte was dropped on a bad stop bit (or bad parity)
- rx_overflow  out  1  sticky; a word was dropped because the FIFO was full

## Operation
- RX front end: 2-flop synchronizer on i_uart_rx. BIT_CNT = CLK_FREQ/BAUD (integer division; 434 at the defaults).
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE→START on a synchronized falling edge.
  - START samples at BIT_CNT/2. A high sample is a glitch and returns to IDLE; a low sample goes to DATA.
  - DATA takes 8 samples, one per BIT_CNT, LSB first.
  - STOP samples once. A high sample yields a good byte. A low sample drops the byte and sets rx_frame_err. Either way the FSM returns to IDLE.
- Packer: byte k (k=0..7) goes to bits [8k+7:8k]. The 8th byte forms a word, which is pushed into the FIFO in the same cycle. If the FIFO is full, the word is discarded, rx_overflow is set and the packer still restarts at k=0.
- DMA FSM states: IDLE, REQ, WAIT_BUSY, XFER, WAIT_DONE.
  - IDLE→REQ when FIFO count ≥ BURST_WORDS and dma_wbusy=0.
  - REQ drives dma_wareq=1 for exactly one cycle, then goes to WAIT_BUSY.
  - WAIT_BUSY→XFER on dma_wbusy=1.
  - XFER: dma_wready = FIFO not empty; dma_wdata = FIFO head. A word pops on the cycle dma_wvalid&&dma_wready. After BURST_WORDS pops, go to WAIT_DONE.
  - WAIT_DONE→IDLE on dma_wbusy=0. In the same cycle, dma_waddr advances by BURST_WORDS*8 and wraps to BASE_ADDR when it reaches BASE_ADDR+BUF_BYTES.
- A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- Partial words and partial bursts stay buffered until complete; nothing is flushed.

## Timing
- Reset values: dma_waddr=BASE_ADDR, dma_wareq=0, dma_wready=0, dma_wdata=0, dma_wsize=BURST_WORDS, rx_frame_err=0, rx_overflow=0. The FIFO is empty, the packer is at k=0 and both FSMs are in IDLE.
- Byte-complete latency: 1 cycle after the stop-bit sample. The FIFO push happens in the same cycle as the 8th byte completes.
- Burst start: dma_wareq asserts on the cycle after the FIFO count reaches BURST_WORDS, provided dma_wbusy=0.
- dma_wdata is a registered FIFO head. It changes only in the cycle after a pop, so back-to-back dma_wvalid sustains 1 word/cycle.
- Reset asserted mid-burst: all state clears immediately, buffered data is lost and dma_waddr returns to BASE_ADDR.
- The sticky flags clear only on reset.

## Configuration
- UART_RX_PARITY_EN defined: frames are 8E1. A PARITY state sits between DATA and STOP. A byte is dropped and rx_frame_err is set if the data-plus-parity XOR is 1 or the stop bit is 0.
- UART_RX_PARITY_EN undefined: frames are 8N1 and there is no PARITY state.

## Test plan
- Send 128 bytes 0x00..0x7F at 115200, dma_wvalid tied high → exactly one dma_wareq with dma_waddr=BASE_ADDR and dma_wsize=16; word0=64'h0706050403020100, word15=64'h7F7E7D7C7B7A7978.
- Send 256 bytes, toggle dma_wvalid every other cycle → two bursts at BASE_ADDR and BASE_ADDR+128; data in order with no duplicates.
- With BUF_BYTES=256, send 384 bytes → third burst address is BASE_ADDR (wrap).
- Frame with stop bit 0 between 8 good bytes → that byte is absent from the packed data and rx_frame_err=1. A 0.3-bit low glitch on i_uart_rx produces no byte.
- Hold dma_wbusy=1 and send 264 bytes (33 words) → FIFO fills at 32 words, the 33rd word is dropped and rx_overflow=1; after dma_wbusy is released, two bursts drain 32 words in order.
- Assert dma_rst_n mid-XFER → dma_wready=0 and dma_waddr=BASE_ADDR on the same edge; a subsequent 128 bytes produce a clean burst.
